// File: rtl/vg64_pkg.sv
// Shared types and constants for the VGA/SRAM write path: register map, tokens
// and the write-request layout handed to the SRAM sequencer.
package vg64_pkg;

  localparam int SRAM_AW = 17;

  typedef enum logic [2:0] {
    REG_TOKEN = 3'd0,
    REG_LSB   = 3'd1,
    REG_MSB   = 3'd2,
    REG_DATA  = 3'd3,
    REG_CTRL  = 3'd4
  } reg_off_e;

  localparam logic [7:0] TOKEN_L = 8'h4C;
  localparam logic [7:0] TOKEN_M = 8'h4D;

  localparam int CTRL_AUTOINC = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [7:0]         data;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } c64_bus_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count; push while full is accepted
// only when a pop happens in the same cycle. No write-to-read bypass.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level/empty gate every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/c64_write_queue.sv
// Snoops C64 writes to the I/O1 register window, builds SRAM addresses and
// queues {addr,data} requests for the SRAM sequencer in the pixel-clock domain.
module c64_write_queue
  import vg64_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hDE00,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_phi2,
  input  logic                        i_rw,
  input  logic [15:0]                 i_addr,
  input  logic [7:0]                  i_data,
  output logic                        o_wr_valid,
  input  logic                        i_wr_ready,
  output logic [SRAM_AW-1:0]          o_wr_addr,
  output logic [7:0]                  o_wr_data,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow
);

  logic [SYNC_STAGES-1:0] phi_q;
  c64_bus_t [SYNC_STAGES-1:0] bus_q;

  // Bus travels alongside PHI2 so the sampled word matches the last pre-fall PHI2 sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi_q <= '0;
      bus_q <= '0;
    end else begin
      phi_q    <= {phi_q[SYNC_STAGES-2:0], i_phi2};
      bus_q[0] <= '{rw: i_rw, addr: i_addr, data: i_data};
      for (int i = 1; i < SYNC_STAGES; i++) bus_q[i] <= bus_q[i-1];
    end
  end

  c64_bus_t    bus_s;
  logic [15:0] reg_diff;
  logic        evt_hit;
  reg_off_e    reg_off;

  assign bus_s    = bus_q[SYNC_STAGES-1];
  assign reg_diff = bus_s.addr - BASE_ADDR;
  assign evt_hit  = !phi_q[SYNC_STAGES-2] && phi_q[SYNC_STAGES-1] && !bus_s.rw
                    && (reg_diff <= 16'(REG_CTRL));
  assign reg_off  = reg_off_e'(reg_diff[2:0]);

  logic               bank_q, bank_d;
  logic [7:0]         msb_q, msb_d;
  logic [7:0]         lsb_q, lsb_d;
  logic               autoinc_q, autoinc_d;
  logic               ovf_q, ovf_d;
  logic [SRAM_AW-1:0] cur_addr, next_addr;

  logic    fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  wr_req_t fifo_wdata, fifo_rdata, last_q, head;

  assign cur_addr   = {bank_q, msb_q, lsb_q};
  assign next_addr  = cur_addr + SRAM_AW'(1);
  assign fifo_pop   = !fifo_empty && i_wr_ready;
  assign fifo_wdata = '{addr: cur_addr, data: bus_s.data};

  always_comb begin
    bank_d     = bank_q;
    msb_d      = msb_q;
    lsb_d      = lsb_q;
    autoinc_d  = autoinc_q;
    ovf_d      = ovf_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (evt_hit) begin
      case (reg_off)
        REG_TOKEN: begin
          if (bus_s.data == TOKEN_L)      bank_d = 1'b0;
          else if (bus_s.data == TOKEN_M) bank_d = 1'b1;
        end
        REG_LSB: lsb_d = bus_s.data;
        REG_MSB: msb_d = bus_s.data;
        REG_DATA: begin
          // A full queue only takes the write if the head leaves this same cycle.
          if (!fifo_full || fifo_pop) begin
            fifo_push = 1'b1;
            if (autoinc_q) {bank_d, msb_d, lsb_d} = next_addr;
          end else begin
            ovf_d = 1'b1;
          end
        end
        REG_CTRL: begin
          autoinc_d  = bus_s.data[CTRL_AUTOINC];
          fifo_flush = bus_s.data[CTRL_FLUSH];
          if (bus_s.data[CTRL_CLR_OVF]) ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= 1'b0;
      msb_q     <= '0;
      lsb_q     <= '0;
      autoinc_q <= 1'b0;
      ovf_q     <= 1'b0;
      last_q    <= '0;
    end else begin
      bank_q    <= bank_d;
      msb_q     <= msb_d;
      lsb_q     <= lsb_d;
      autoinc_q <= autoinc_d;
      ovf_q     <= ovf_d;
      if (!fifo_empty) last_q <= fifo_rdata;
    end
  end

  sync_fifo #(
    .WIDTH (WR_REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (o_level)
  );

  // The port shows the last delivered request while the queue is empty.
  assign head       = fifo_empty ? last_q : fifo_rdata;
  assign o_wr_valid = !fifo_empty;
  assign o_wr_addr  = head.addr;
  assign o_wr_data  = head.data;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_c64_write_queue.sv
// Directed bench for c64_write_queue: register map, latency, handshake,
// overflow, flush, ignored accesses and reset mid-queue.
module tb_c64_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_phi2;
  logic        i_rw;
  logic [15:0] i_addr;
  logic [7:0]  i_data;
  logic        o_wr_valid;
  logic        i_wr_ready;
  logic [16:0] o_wr_addr;
  logic [7:0]  o_wr_data;
  logic [2:0]  o_level;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  logic [24:0] popped[$];

  c64_write_queue dut (
    .clk        (clk),
    .rst        (rst),
    .i_phi2     (i_phi2),
    .i_rw       (i_rw),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .o_wr_valid (o_wr_valid),
    .i_wr_ready (i_wr_ready),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  always #20 clk = ~clk;

  // Record every accepted request; inputs only change on negedge, so this reflects the next posedge.
  always @(negedge clk) begin
    #1;
    if (!rst && o_wr_valid && i_wr_ready) popped.push_back({o_wr_addr, o_wr_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // One 6510 bus cycle: bus stable while PHI2 high, PHI2 falls, bus released later.
  task automatic c64_access(input logic rw, input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    i_rw   = rw;
    i_addr = addr;
    i_data = data;
    i_phi2 = 1'b1;
    repeat (3) @(negedge clk);
    i_phi2 = 1'b0;
    repeat (5) @(negedge clk);
    i_rw   = 1'b1;
  endtask

  task automatic c64_write(input logic [15:0] addr, input logic [7:0] data);
    c64_access(1'b0, addr, data);
  endtask

  task automatic drain();
    i_wr_ready = 1'b1;
    for (int i = 0; i < 16 && o_level != 3'd0; i++) @(negedge clk);
    i_wr_ready = 1'b0;
    checks++;
    if (o_level !== 3'd0) begin
      errors++;
      $display("FAIL drain: level got %0d required 0", o_level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_phi2 = 1'b0; i_rw = 1'b1; i_addr = '0; i_data = '0; i_wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", o_wr_valid); end
    checks++; if (o_wr_addr !== 17'h0) begin errors++; $display("FAIL reset_addr: got %05h required 00000", o_wr_addr); end
    checks++; if (o_wr_data !== 8'h0) begin errors++; $display("FAIL reset_data: got %02h required 00", o_wr_data); end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", o_level); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b required 0", o_overflow); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_write();
    c64_write(16'hDE00, 8'h4D);
    c64_write(16'hDE01, 8'h12);
    c64_write(16'hDE02, 8'h34);
    // DATA write done by hand to pin down the event-to-valid latency.
    @(negedge clk);
    i_rw = 1'b0; i_addr = 16'hDE03; i_data = 8'hAA; i_phi2 = 1'b1;
    repeat (3) @(negedge clk);
    i_phi2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid got %0b required 0", o_wr_valid); end
    @(negedge clk);
    checks++; if (o_wr_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: valid got %0b required 1", o_wr_valid); end
    repeat (3) @(negedge clk);
    i_rw = 1'b1;
    checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d required 1", o_level); end
    checks++; if (o_wr_addr !== 17'h13412) begin errors++; $display("FAIL basic_addr: got %05h required 13412", o_wr_addr); end
    checks++; if (o_wr_data !== 8'hAA) begin errors++; $display("FAIL basic_data: got %02h required AA", o_wr_data); end
    popped.delete();
    drain();
    checks++; if (popped.size() != 1) begin errors++; $display("FAIL basic_pops: got %0d required 1", popped.size()); end
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %0b required 0", o_wr_valid); end
    checks++; if (o_wr_addr !== 17'h13412) begin errors++; $display("FAIL basic_hold_addr: got %05h required 13412", o_wr_addr); end
  endtask

  task automatic test_autoinc_wrap();
    logic [24:0] exp_q [2];
    exp_q[0] = {17'h1FFFF, 8'h55};
    exp_q[1] = {17'h00000, 8'h66};
    popped.delete();
    i_wr_ready = 1'b1;
    c64_write(16'hDE04, 8'h01);
    c64_write(16'hDE00, 8'h4D);
    c64_write(16'hDE01, 8'hFF);
    c64_write(16'hDE02, 8'hFF);
    c64_write(16'hDE03, 8'h55);
    c64_write(16'hDE03, 8'h66);
    repeat (2) @(negedge clk);
    i_wr_ready = 1'b0;
    checks++; if (popped.size() != 2) begin errors++; $display("FAIL wrap_pops: got %0d required 2", popped.size()); end
    for (int i = 0; i < 2 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_req%0d: got %07h required %07h", i, popped[i], exp_q[i]);
      end
    end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL wrap_level: got %0d required 0", o_level); end
  endtask

  task automatic test_overflow();
    c64_write(16'hDE00, 8'h4C);
    c64_write(16'hDE01, 8'h00);
    c64_write(16'hDE02, 8'h10);
    for (int i = 0; i < 5; i++) c64_write(16'hDE03, 8'h10 + 8'(i));
    checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d required 4", o_level); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b required 1", o_overflow); end
    checks++; if (o_wr_addr !== 17'h01000 || o_wr_data !== 8'h10) begin
      errors++; $display("FAIL ovf_head: got %05h/%02h required 01000/10", o_wr_addr, o_wr_data);
    end
  endtask

  task automatic test_full_with_pop();
    logic [24:0] exp_q [5];
    exp_q[0] = {17'h01000, 8'h10};
    exp_q[1] = {17'h01001, 8'h11};
    exp_q[2] = {17'h01002, 8'h12};
    exp_q[3] = {17'h01003, 8'h13};
    exp_q[4] = {17'h01004, 8'h20};
    popped.delete();
    // Raise ready only for the edge that also carries the DATA enqueue.
    @(negedge clk);
    i_rw = 1'b0; i_addr = 16'hDE03; i_data = 8'h20; i_phi2 = 1'b1;
    repeat (3) @(negedge clk);
    i_phi2 = 1'b0;
    repeat (2) @(negedge clk);
    i_wr_ready = 1'b1;
    @(negedge clk);
    i_wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    i_rw = 1'b1;
    checks++; if (o_level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d required 4", o_level); end
    checks++; if (o_wr_addr !== 17'h01001 || o_wr_data !== 8'h11) begin
      errors++; $display("FAIL fullpop_head: got %05h/%02h required 01001/11", o_wr_addr, o_wr_data);
    end
    drain();
    checks++; if (popped.size() != 5) begin errors++; $display("FAIL fullpop_pops: got %0d required 5", popped.size()); end
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== exp_q[i]) begin
        errors++; $display("FAIL fullpop_req%0d: got %07h required %07h", i, popped[i], exp_q[i]);
      end
    end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b required 1", o_overflow); end
    c64_write(16'hDE04, 8'h05);
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b required 0", o_overflow); end
  endtask

  task automatic test_ignored();
    c64_write(16'hDE04, 8'h00);
    c64_write(16'hDE00, 8'h4D);
    c64_access(1'b1, 16'hDE00, 8'h4C);
    c64_access(1'b1, 16'hDE03, 8'h99);
    c64_write(16'hDE05, 8'h4C);
    c64_write(16'hDF00, 8'h4C);
    c64_write(16'hDDFF, 8'h4C);
    c64_write(16'hDE00, 8'h41);
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL ignored_level: got %0d required 0", o_level); end
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL ignored_valid: got %0b required 0", o_wr_valid); end
    c64_write(16'hDE03, 8'h77);
    checks++; if (o_level !== 3'd1) begin errors++; $display("FAIL ignored_push_level: got %0d required 1", o_level); end
    checks++; if (o_wr_addr !== 17'h11005 || o_wr_data !== 8'h77) begin
      errors++; $display("FAIL ignored_head: got %05h/%02h required 11005/77", o_wr_addr, o_wr_data);
    end
  endtask

  task automatic test_flush();
    c64_write(16'hDE03, 8'h88);
    c64_write(16'hDE03, 8'h99);
    checks++; if (o_level !== 3'd3) begin errors++; $display("FAIL flush_pre_level: got %0d required 3", o_level); end
    c64_write(16'hDE04, 8'h02);
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d required 0", o_level); end
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b required 0", o_wr_valid); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %0b required 0", o_overflow); end
  endtask

  task automatic test_reset_mid_queue();
    logic [24:0] exp_q [2];
    exp_q[0] = {17'h00000, 8'hAB};
    exp_q[1] = {17'h00000, 8'hCD};
    c64_write(16'hDE04, 8'h01);
    c64_write(16'hDE00, 8'h4D);
    c64_write(16'hDE01, 8'h21);
    c64_write(16'hDE03, 8'h01);
    c64_write(16'hDE03, 8'h02);
    checks++; if (o_level !== 3'd2) begin errors++; $display("FAIL rstq_pre_level: got %0d required 2", o_level); end
    // Assert reset halfway through a bus cycle with PHI2 high.
    @(negedge clk);
    i_rw = 1'b0; i_addr = 16'hDE03; i_data = 8'h03; i_phi2 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    i_rw = 1'b1;
    repeat (4) @(negedge clk);
    i_phi2 = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL rstq_valid: got %0b required 0", o_wr_valid); end
    checks++; if (o_wr_addr !== 17'h0 || o_wr_data !== 8'h0) begin
      errors++; $display("FAIL rstq_head: got %05h/%02h required 00000/00", o_wr_addr, o_wr_data);
    end
    checks++; if (o_level !== 3'd0) begin errors++; $display("FAIL rstq_level: got %0d required 0", o_level); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rstq_overflow: got %0b required 0", o_overflow); end
    popped.delete();
    c64_write(16'hDE03, 8'hAB);
    c64_write(16'hDE03, 8'hCD);
    checks++; if (o_level !== 3'd2) begin errors++; $display("FAIL rstq_post_level: got %0d required 2", o_level); end
    drain();
    checks++; if (popped.size() != 2) begin errors++; $display("FAIL rstq_pops: got %0d required 2", popped.size()); end
    for (int i = 0; i < 2 && i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstq_req%0d: got %07h required %07h", i, popped[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_autoinc_wrap();
    test_overflow();
    test_full_with_pop();
    test_ignored();
    test_flush();
    test_reset_mid_queue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
